// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-owner tags and the
// request bundle used on the core, loader and memory sides.
package dmem_arbiter_pkg;

    localparam int DMEM_AW = 9;
    localparam int DMEM_DW = 32;

    typedef enum logic {
        CORE_PRI,
        LD_FORCE
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_LD
    } rd_owner_e;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
        logic [2:0]         func3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_req_mux.sv
// Combinational 2:1 select of the request bundle driven onto the memory port;
// an idle (all-zero) bundle is presented when neither side holds the grant.
module dmem_req_mux
    import dmem_arbiter_pkg::*;
(
    input  dmem_req_t i_core,
    input  dmem_req_t i_ld,
    input  logic      i_grant_core,
    input  logic      i_grant_ld,
    output dmem_req_t o_mem
);

    always_comb begin
        o_mem = '0;
        if (i_grant_core) begin
            o_mem = i_core;
        end else if (i_grant_ld) begin
            o_mem = i_ld;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage and the loader: core first,
// with a starvation counter that forces one loader grant after a run of conflicts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    // Address/data widths must match the package bundle widths.
    parameter int DM_ADDRESS = DMEM_AW,
    parameter int DATA_W     = DMEM_DW,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  ld_valid,
    input  logic                  ld_we,
    input  logic [DM_ADDRESS-1:0] ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    input  logic [2:0]            ld_func3,
    output logic                  ld_ready,
    output logic                  ld_rvalid,
    output logic [DATA_W-1:0]     ld_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [3:0] LIM_M1 = 4'(STARVE_LIM - 1);

    arb_state_e r_state;
    arb_state_e w_next_state;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_next_cnt;
    rd_owner_e  r_rd_owner;
    rd_owner_e  w_next_owner;

    logic       w_core_any;
    logic       w_grant_core;
    logic       w_grant_ld;
    dmem_req_t  w_core_req;
    dmem_req_t  w_ld_req;
    dmem_req_t  w_mem_req;

    assign w_core_any = core_rd | core_wr;

    // A simultaneous rd+wr from the core is treated as a write.
    assign w_core_req = '{rd: core_rd & ~core_wr, wr: core_wr, addr: core_addr,
                          wdata: core_wdata, func3: core_func3};
    assign w_ld_req   = '{rd: ~ld_we, wr: ld_we, addr: ld_addr,
                          wdata: ld_wdata, func3: ld_func3};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CORE_PRI;
            r_starve_cnt <= '0;
            r_rd_owner   <= OWN_NONE;
        end else begin
            r_state      <= w_next_state;
            r_starve_cnt <= w_next_cnt;
            r_rd_owner   <= w_next_owner;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_starve_cnt;
        w_grant_core = 1'b0;
        w_grant_ld   = 1'b0;
        case (r_state)
            CORE_PRI: begin
                if (w_core_any) begin
                    w_grant_core = 1'b1;
                    if (ld_valid) begin
                        w_next_cnt = r_starve_cnt + 4'd1;
                        if (r_starve_cnt == LIM_M1) begin
                            w_next_state = LD_FORCE;
                        end
                    end
                end else if (ld_valid) begin
                    w_grant_ld = 1'b1;
                    w_next_cnt = '0;
                end
            end
            LD_FORCE: begin
                // Forced slot lasts exactly one cycle, even if the loader withdrew.
                w_next_state = CORE_PRI;
                w_next_cnt   = '0;
                if (ld_valid) begin
                    w_grant_ld = 1'b1;
                end else begin
                    w_grant_core = w_core_any;
                end
            end
            default: begin
                w_next_state = CORE_PRI;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_next_owner = OWN_NONE;
        if (w_grant_core && w_core_req.rd) begin
            w_next_owner = OWN_CORE;
        end else if (w_grant_ld && w_ld_req.rd) begin
            w_next_owner = OWN_LD;
        end
    end

    dmem_req_mux u_req_mux (
        .i_core       (w_core_req),
        .i_ld         (w_ld_req),
        .i_grant_core (w_grant_core),
        .i_grant_ld   (w_grant_ld),
        .o_mem        (w_mem_req)
    );

    assign mem_rd     = w_mem_req.rd;
    assign mem_wr     = w_mem_req.wr;
    assign mem_addr   = w_mem_req.addr;
    assign mem_wdata  = w_mem_req.wdata;
    assign mem_func3  = w_mem_req.func3;

    assign core_stall = w_core_any & ~w_grant_core;
    assign ld_ready   = w_grant_ld;
    assign ld_rvalid  = (r_rd_owner == OWN_LD);
    assign ld_rdata   = mem_rdata;
    assign core_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// scored against a grant-order reference model with its own memory image.
module tb_dmem_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_func3;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          ld_valid, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [2:0]    ld_func3;
    logic          ld_ready, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_func3;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] tbMem  [0:511];
    logic [DW-1:0] refMem [0:511];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_stall(core_stall), .core_rdata(core_rdata),
        .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_func3(ld_func3),
        .ld_ready(ld_ready), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
    );

    // Behavioural datamemory: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_wr) tbMem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= tbMem[mem_addr];
    end

    task automatic idleInputs;
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = 3'b010;
        ld_valid = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_func3 = 3'b010;
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        idleInputs();
        reset = 1'b0;
        nextCycle();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idleInputs();
        reset = 1'b0;
        #2;
        checks++; if (ld_rvalid !== 1'b0) $display("[TB] FAIL reset_rvalid: got %b expected 0", ld_rvalid); else passes++;
        checks++; if ({mem_rd, mem_wr, mem_addr} !== '0) $display("[TB] FAIL reset_membus: got %b%b %h expected 0", mem_rd, mem_wr, mem_addr); else passes++;
        checks++; if ({core_stall, ld_ready} !== 2'b00) $display("[TB] FAIL reset_handshake: got %b expected 00", {core_stall, ld_ready}); else passes++;
        nextCycle();
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        doReset();
        ld_valid = 1; ld_we = 0; ld_addr = 9'h010;
        #2;
        checks++; if (ld_ready !== 1'b1) $display("[TB] FAIL midrd_ready: got %b expected 1", ld_ready); else passes++;
        nextCycle();
        ld_valid = 0;
        #1;
        checks++; if (ld_rvalid !== 1'b1) $display("[TB] FAIL midrd_rvalid_pre: got %b expected 1", ld_rvalid); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (ld_rvalid !== 1'b0) $display("[TB] FAIL midrd_rvalid_drop: got %b expected 0", ld_rvalid); else passes++;
        checks++; if (mem_rd !== 1'b0) $display("[TB] FAIL midrd_memrd: got %b expected 0", mem_rd); else passes++;
        nextCycle();
        reset = 1'b1;
        core_rd = 1; core_addr = 9'h011; ld_valid = 1;
        for (int c = 0; c < LIM + 1; c++) begin
            #2;
            checks++; if (ld_ready !== (c == LIM)) $display("[TB] FAIL midrd_cnt_cycle%0d: got ld_ready %b expected %b", c, ld_ready, c == LIM); else passes++;
            nextCycle();
        end
        idleInputs();
    endtask

    task automatic test_loader_only;
        doReset();
        ld_valid = 1; ld_we = 1; ld_addr = 9'h010; ld_wdata = 32'hDEADBEEF;
        #2;
        checks++; if ({ld_ready, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h010, 32'hDEADBEEF})
            $display("[TB] FAIL ld_write: got rdy %b wr %b addr %h data %h expected 1 1 010 deadbeef", ld_ready, mem_wr, mem_addr, mem_wdata); else passes++;
        nextCycle();
        ld_we = 0;
        #2;
        checks++; if ({ld_ready, mem_rd} !== 2'b11) $display("[TB] FAIL ld_read_grant: got %b expected 11", {ld_ready, mem_rd}); else passes++;
        nextCycle();
        ld_valid = 0;
        #2;
        checks++; if (ld_rvalid !== 1'b1) $display("[TB] FAIL ld_rvalid: got %b expected 1", ld_rvalid); else passes++;
        checks++; if (ld_rdata !== 32'hDEADBEEF) $display("[TB] FAIL ld_rdata: got %h expected deadbeef", ld_rdata); else passes++;
        nextCycle();
    endtask

    task automatic test_core_only;
        doReset();
        core_wr = 1; core_addr = 9'h020; core_wdata = 32'h12345678;
        #2;
        checks++; if ({core_stall, ld_ready, mem_wr} !== 3'b001) $display("[TB] FAIL core_sw: got %b expected 001", {core_stall, ld_ready, mem_wr}); else passes++;
        nextCycle();
        core_wr = 0; core_rd = 1;
        #2;
        checks++; if ({core_stall, mem_rd, mem_addr} !== {1'b0, 1'b1, 9'h020}) $display("[TB] FAIL core_lw: got %b %b %h expected 0 1 020", core_stall, mem_rd, mem_addr); else passes++;
        nextCycle();
        core_rd = 0;
        #2;
        checks++; if (core_rdata !== 32'h12345678) $display("[TB] FAIL core_rdata: got %h expected 12345678", core_rdata); else passes++;
        checks++; if (ld_rvalid !== 1'b0) $display("[TB] FAIL core_rd_owner: got ld_rvalid %b expected 0", ld_rvalid); else passes++;
        nextCycle();
    endtask

    task automatic test_conflict;
        doReset();
        core_rd = 1; core_addr = 9'h040; ld_valid = 1; ld_we = 0; ld_addr = 9'h041;
        for (int c = 0; c < 2 * (LIM + 1); c++) begin
            #2;
            checks++; if ({ld_ready, core_stall} !== {2{(c % (LIM + 1)) == LIM}})
                $display("[TB] FAIL conflict_cycle%0d: got ready/stall %b%b expected %b", c, ld_ready, core_stall, (c % (LIM + 1)) == LIM); else passes++;
            nextCycle();
        end
        idleInputs();
    endtask

    task automatic test_forced_write;
        doReset();
        core_rd = 1; core_addr = 9'h030;
        ld_valid = 1; ld_we = 1; ld_addr = 9'h030; ld_wdata = 32'hA5A5A5A5;
        for (int c = 0; c <= LIM; c++) begin
            #2;
            checks++; if ({ld_ready, core_stall} !== {2{c == LIM}}) $display("[TB] FAIL fwr_cycle%0d: got %b%b expected %b", c, ld_ready, core_stall, c == LIM); else passes++;
            nextCycle();
        end
        ld_valid = 0;
        #2;
        checks++; if ({core_stall, mem_rd} !== 2'b01) $display("[TB] FAIL fwr_regrant: got %b expected 01", {core_stall, mem_rd}); else passes++;
        nextCycle();
        core_rd = 0;
        #2;
        checks++; if (core_rdata !== 32'hA5A5A5A5) $display("[TB] FAIL fwr_rdata: got %h expected a5a5a5a5", core_rdata); else passes++;
        nextCycle();
    endtask

    task automatic test_withdraw;
        doReset();
        core_rd = 1; core_addr = 9'h050; ld_valid = 1; ld_we = 0; ld_addr = 9'h051;
        for (int c = 0; c < LIM; c++) nextCycle();
        ld_valid = 0;
        #2;
        checks++; if ({core_stall, ld_ready, mem_rd, mem_addr} !== {3'b001, 9'h050})
            $display("[TB] FAIL withdraw_grant: got %b%b%b %h expected 001 050", core_stall, ld_ready, mem_rd, mem_addr); else passes++;
        nextCycle();
        ld_valid = 1;
        for (int c = 0; c <= LIM; c++) begin
            #2;
            checks++; if (ld_ready !== (c == LIM)) $display("[TB] FAIL withdraw_cnt_cycle%0d: got %b expected %b", c, ld_ready, c == LIM); else passes++;
            nextCycle();
        end
        idleInputs();
    endtask

    task automatic test_random;
        int wins;
        bit forced, coreReq, gC, gL, coreHold, ldHold, ownLd, ownCore;
        logic [DW-1:0] expData;
        logic [45:0] expBus;
        int r;
        doReset();
        wins = 0; coreHold = 0; ldHold = 0; ownLd = 0; ownCore = 0; expData = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!coreHold) begin
                r = $urandom_range(0, 9);
                core_rd = (r < 4) || (r == 9);
                core_wr = (r >= 4 && r < 7) || (r == 9);
                core_addr = 9'h100 | 9'($urandom_range(0, 15));
                core_wdata = $urandom;
                core_func3 = 3'($urandom);
            end
            if (!ldHold) begin
                ld_valid = ($urandom_range(0, 9) < 6);
                ld_we = 1'($urandom_range(0, 1));
                ld_addr = 9'h100 | 9'($urandom_range(0, 15));
                ld_wdata = $urandom;
                ld_func3 = 3'($urandom);
            end
            coreReq = core_rd | core_wr;
            forced = (wins == LIM);
            gC = forced ? (!ld_valid && coreReq) : coreReq;
            gL = forced ? ld_valid : (!coreReq && ld_valid);
            expBus = '0;
            if (gC) expBus = {core_rd & ~core_wr, core_wr, core_addr, core_wdata, core_func3};
            if (gL) expBus = {~ld_we, ld_we, ld_addr, ld_wdata, ld_func3};
            #2;
            checks++; if ({core_stall, ld_ready} !== {coreReq && !gC, gL})
                $display("[TB] FAIL rnd_grant_c%0d: got stall/ready %b%b expected %b%b", cyc, core_stall, ld_ready, coreReq && !gC, gL); else passes++;
            checks++; if ({mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3} !== expBus)
                $display("[TB] FAIL rnd_membus_c%0d: got %h expected %h", cyc, {mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3}, expBus); else passes++;
            checks++; if (ld_rvalid !== ownLd) $display("[TB] FAIL rnd_rvalid_c%0d: got %b expected %b", cyc, ld_rvalid, ownLd); else passes++;
            if (ownLd) begin
                checks++; if (ld_rdata !== expData) $display("[TB] FAIL rnd_ldrdata_c%0d: got %h expected %h", cyc, ld_rdata, expData); else passes++;
            end
            if (ownCore) begin
                checks++; if (core_rdata !== expData) $display("[TB] FAIL rnd_corerdata_c%0d: got %h expected %h", cyc, core_rdata, expData); else passes++;
            end
            ownCore = gC && core_rd && !core_wr;
            ownLd = gL && !ld_we;
            if (ownCore) expData = refMem[core_addr];
            if (ownLd) expData = refMem[ld_addr];
            if (gC && core_wr) refMem[core_addr] = core_wdata;
            if (gL && ld_we) refMem[ld_addr] = ld_wdata;
            if (forced) wins = 0;
            else if (coreReq && ld_valid) wins++;
            else if (gL) wins = 0;
            coreHold = coreReq && !gC;
            ldHold = ld_valid && !gL;
            nextCycle();
        end
        idleInputs();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            tbMem[i] = '0;
            refMem[i] = '0;
        end
        mem_rdata = '0;
        test_reset();
        test_reset_mid_read();
        test_loader_only();
        test_core_only();
        test_conflict();
        test_forced_write();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
